// File: rtl/lcd_text_buffer.sv
// +---------------------------------------------------------------------------+
// | Module      : lcd_text_buffer                                             |
// | Description : Character buffer for a text LCD. A host byte stream is      |
// |               written at a cursor and a display driver reads characters   |
// |               back. A refresh request is raised whenever contents change. |
// | Option      : define LCD_TEXT_BUFFER_CTRL_EN to decode FF/CR/LF codes     |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

module lcd_text_buffer #(
  parameter int         LINE_WIDTH = 16,
  parameter int         NUM_LINES  = 4,
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  localparam int        DEPTH      = LINE_WIDTH * NUM_LINES,
  localparam int        AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          trg,
  input  logic          busy,
  output logic [AW-1:0] cursor
);

  localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

  localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
  localparam logic [CW-1:0] c_last_col  = CW'(LINE_WIDTH - 1);

`ifdef LCD_TEXT_BUFFER_CTRL_EN
  localparam logic [7:0]    c_code_lf   = 8'h0A;
  localparam logic [7:0]    c_code_ff   = 8'h0C;
  localparam logic [7:0]    c_code_cr   = 8'h0D;
  localparam logic [AW-1:0] c_last_line = AW'((NUM_LINES - 1) * LINE_WIDTH);
  localparam logic [AW-1:0] c_line_step = AW'(LINE_WIDTH);
`endif

  typedef enum logic [0:0] {
    W_CLEAR = 1'b0,
    W_IDLE  = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_WAIT_HI = 2'd1,
    R_WAIT_LO = 2'd2
  } rf_state_t;

  wr_state_t     r_wr_state, w_wr_state_nxt;
  rf_state_t     r_rf_state, w_rf_state_nxt;
  logic [AW-1:0] r_clr_addr, w_clr_addr_nxt;
  logic [AW-1:0] r_cursor,   w_cursor_nxt;
  logic [CW-1:0] r_col,      w_col_nxt;
  logic          r_dirty,    w_dirty_nxt;
  logic [7:0]    r_rd_data;

  logic [7:0]    r_mem [DEPTH];

  logic          w_xfer;
  logic          w_store;
  logic          w_dirty_set;
  logic          w_trg;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [7:0]    w_mem_wdata;

`ifdef LCD_TEXT_BUFFER_CTRL_EN
  logic [AW-1:0] w_line_start;
  logic [AW-1:0] w_next_line;

  // The column counter lets line arithmetic avoid a divider.
  assign w_line_start = r_cursor - AW'(r_col);
  assign w_next_line  = (w_line_start == c_last_line) ? '0 : w_line_start + c_line_step;
`endif

  assign w_xfer   = wr_valid & wr_ready;
  assign wr_ready = (r_wr_state == W_IDLE);
  assign cursor   = r_cursor;
  assign rd_data  = r_rd_data;
  assign trg      = w_trg;

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_clr_addr_nxt = r_clr_addr;
    w_cursor_nxt   = r_cursor;
    w_col_nxt      = r_col;
    w_store        = 1'b0;
    w_dirty_set    = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr     = r_cursor;
    w_mem_wdata    = wr_data;

    case (r_wr_state)
      W_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clr_addr;
        w_mem_wdata = CLEAR_CHAR;
        if (r_clr_addr == c_last_addr) begin
          w_wr_state_nxt = W_IDLE;
          w_clr_addr_nxt = '0;
          w_cursor_nxt   = '0;
          w_col_nxt      = '0;
          w_dirty_set    = 1'b1;
        end else begin
          w_clr_addr_nxt = r_clr_addr + 1'b1;
        end
      end

      W_IDLE: begin
        if (w_xfer) begin
          w_dirty_set = 1'b1;
`ifdef LCD_TEXT_BUFFER_CTRL_EN
          if (wr_data == c_code_ff) begin
            w_wr_state_nxt = W_CLEAR;
            w_clr_addr_nxt = '0;
          end else if (wr_data == c_code_cr) begin
            w_cursor_nxt = w_line_start;
            w_col_nxt    = '0;
          end else if (wr_data == c_code_lf) begin
            w_cursor_nxt = w_next_line;
            w_col_nxt    = '0;
          end else begin
            w_store = 1'b1;
          end
`else
          w_store = 1'b1;
`endif
        end
      end

      default: begin
        w_wr_state_nxt = W_CLEAR;
        w_clr_addr_nxt = '0;
      end
    endcase

    if (w_store) begin
      w_mem_we     = 1'b1;
      w_mem_addr   = r_cursor;
      w_cursor_nxt = (r_cursor == c_last_addr) ? '0 : r_cursor + 1'b1;
      w_col_nxt    = (r_col == c_last_col) ? '0 : r_col + 1'b1;
    end
  end

  // Refresh handshake: pulse trg, then wait for one full busy high/low cycle.
  always_comb begin
    w_rf_state_nxt = r_rf_state;
    w_trg          = 1'b0;

    case (r_rf_state)
      R_IDLE: begin
        if (r_dirty && !busy && (r_wr_state == W_IDLE)) begin
          w_trg          = 1'b1;
          w_rf_state_nxt = R_WAIT_HI;
        end
      end
      R_WAIT_HI: begin
        if (busy) begin
          w_rf_state_nxt = R_WAIT_LO;
        end
      end
      R_WAIT_LO: begin
        if (!busy) begin
          w_rf_state_nxt = R_IDLE;
        end
      end
      default: begin
        w_rf_state_nxt = R_IDLE;
      end
    endcase
  end

  // A change landing in the trigger cycle must not be lost.
  assign w_dirty_nxt = w_dirty_set | (r_dirty & ~w_trg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_state <= W_CLEAR;
      r_rf_state <= R_IDLE;
      r_clr_addr <= '0;
      r_cursor   <= '0;
      r_col      <= '0;
      r_dirty    <= 1'b0;
      r_rd_data  <= 8'h00;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rf_state <= w_rf_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
      r_cursor   <= w_cursor_nxt;
      r_col      <= w_col_nxt;
      r_dirty    <= w_dirty_nxt;
      r_rd_data  <= r_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

endmodule

`default_nettype wire
